// File: rtl/mod_74x32_tester.sv
// Go/no-go tester for a 74x32 quad 2-input OR: applies four vectors to all gates and
// reports per-gate mismatches. Define STOP_ON_FAIL_EN to end the run at the first failing check.
module mod_74x32_tester #(
    parameter int unsigned SETTLE = 20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] Y,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [3:0] FAIL_MASK,
    output logic [1:0] FAIL_VEC
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  vec_q, vec_d;
    logic [3:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic        pass_q, pass_d;
    logic [3:0]  fail_mask_q, fail_mask_d;
    logic [1:0]  fail_vec_q, fail_vec_d;
    logic [3:0]  mism;
    logic [1:0]  vec_nxt;
    logic        stop_hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        a_d         = a_q;
        b_d         = b_q;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        fail_vec_d  = fail_vec_q;
        mism        = Y ^ (a_q | b_q);
        vec_nxt     = vec_q + 2'd1;
`ifdef STOP_ON_FAIL_EN
        stop_hit    = |mism;
`else
        stop_hit    = 1'b0;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d     = ST_SETTLE;
                    cnt_d       = 8'd0;
                    vec_d       = 2'd0;
                    a_d         = 4'hF;
                    b_d         = 4'hF;
                    pass_d      = 1'b0;
                    fail_mask_d = 4'h0;
                    fail_vec_d  = 2'd0;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                fail_mask_d = fail_mask_q | mism;
                if ((fail_mask_q == 4'h0) && (mism != 4'h0)) begin
                    fail_vec_d = vec_q;
                end
                cnt_d = 8'd0;
                if ((vec_q == 2'd3) || stop_hit) begin
                    state_d = ST_DONE;
                    a_d     = 4'h0;
                    b_d     = 4'h0;
                    pass_d  = ((fail_mask_q | mism) == 4'h0);
                end else begin
                    // Vector encoding: bit0 low => A high, bit1 low => B high.
                    state_d = ST_SETTLE;
                    vec_d   = vec_nxt;
                    a_d     = {4{~vec_nxt[0]}};
                    b_d     = {4{~vec_nxt[1]}};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            vec_q       <= 2'd0;
            a_q         <= 4'h0;
            b_q         <= 4'h0;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'h0;
            fail_vec_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            fail_vec_q  <= fail_vec_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign BUSY      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign DONE      = (state_q == ST_DONE);
    assign PASS      = pass_q;
    assign FAIL_MASK = fail_mask_q;
    assign FAIL_VEC  = fail_vec_q;

endmodule

// File: tb/tb_mod_74x32_tester.sv
// Scoreboard bench for mod_74x32_tester: stuck-at faults are injected on Y, a vector-level
// model predicts each run's result, and a monitor checks it when DONE rises.
module tb_mod_74x32_tester;
    localparam int S = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [3:0] Y = 4'h0;
    logic [3:0] A, B, FAIL_MASK;
    logic       BUSY, DONE, PASS;
    logic [1:0] FAIL_VEC;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int run_start = 0;
    logic [3:0] s0 = 4'h0;
    logic [3:0] s1 = 4'h0;
    logic       glitch = 1'b0;
    logic       done_prev = 1'b0;

    typedef struct {
        int         start;
        int         lat;
        logic       pass;
        logic [3:0] mask;
        logic [1:0] vec;
    } exp_t;

    exp_t q[$];

    mod_74x32_tester #(.SETTLE(S)) dut (
        .CLK(CLK), .RST(RST), .START(START), .Y(Y), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .FAIL_MASK(FAIL_MASK), .FAIL_VEC(FAIL_VEC)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Vector table: 0=(1,1) 1=(0,1) 2=(1,0) 3=(0,0), same on every gate.
    function automatic exp_t model(logic [3:0] f0, logic [3:0] f1);
        bit va[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        bit vb[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        exp_t e;
        logic [3:0] good, y, m;
        int last = 3;
        bit stopped = 0;
        e.mask = 4'h0;
        e.vec = 2'd0;
        e.start = 0;
        for (int k = 0; k < 4; k++) begin
            if (!stopped) begin
                good = (va[k] || vb[k]) ? 4'hF : 4'h0;
                y = (good & ~f0) | f1;
                m = y ^ good;
                if (e.mask == 4'h0 && m != 4'h0) e.vec = 2'(k);
                e.mask = e.mask | m;
`ifdef STOP_ON_FAIL_EN
                if (m != 4'h0) begin
                    last = k;
                    stopped = 1;
                end
`endif
            end
        end
        e.lat = (last + 1) * (S + 1);
        e.pass = (e.mask == 4'h0);
        return e;
    endfunction

    // Device-under-test stand-in; with glitch set, Y is garbage outside CHECK cycles.
    always @(negedge CLK) begin : ydrv
        int c;
        c = cyc - run_start;
        if (glitch && BUSY && ((c + 1) % (S + 1) != 0))
            Y = 4'($urandom);
        else
            Y = ((A | B) & ~s0) | s1;
    end

    always @(negedge CLK) begin : mon
        exp_t e;
        if (DONE && !done_prev) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("done_latency", 32'(cyc - e.start), 32'(e.lat));
                chk("pass", 32'(PASS), 32'(e.pass));
                chk("fail_mask", 32'(FAIL_MASK), 32'(e.mask));
                chk("fail_vec", 32'(FAIL_VEC), 32'(e.vec));
                chk("done_ab_zero", {24'h0, A, B}, 32'h0);
                chk("done_busy", 32'(BUSY), 32'h0);
            end
        end
        done_prev = DONE;
    end

    task automatic issue(logic [3:0] f0, logic [3:0] f1, logic g);
        exp_t e;
        s0 = f0;
        s1 = f1;
        glitch = g;
        e = model(f0, f1);
        e.start = cyc + 1;
        run_start = cyc + 1;
        q.push_back(e);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=pending required=done", name);
            q.delete();
        end
    endtask

    task automatic chk_all_zero(string name);
        chk(name, {16'h0, A, B, FAIL_MASK, BUSY, DONE, PASS, FAIL_VEC, 1'b0}, 32'h0);
    endtask

    initial begin
        exp_t e;
        int n;
        RST = 1'b1;
        START = 1'b0;
        repeat (3) @(negedge CLK);
        chk_all_zero("reset_outputs");
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("idle_busy", 32'(BUSY), 32'h0);
        chk("idle_done", 32'(DONE), 32'h0);

        issue(4'h0, 4'h0, 1'b0);
        chk("vec0_a", 32'(A), 32'hF);
        chk("vec0_b", 32'(B), 32'hF);
        chk("busy_after_start", 32'(BUSY), 32'h1);
        wait_drain("good");
        issue(4'b0100, 4'h0, 1'b0);
        wait_drain("gate3_stuck0");
        issue(4'h0, 4'b0001, 1'b0);
        wait_drain("gate1_stuck1");

        // Restart after a failing run clears results on the START edge; mid-run START ignored.
        issue(4'h0, 4'h0, 1'b1);
        chk("restart_mask_clr", 32'(FAIL_MASK), 32'h0);
        chk("restart_vec_clr", 32'(FAIL_VEC), 32'h0);
        chk("restart_pass_clr", 32'(PASS), 32'h0);
        chk("restart_done_clr", 32'(DONE), 32'h0);
        repeat (3) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_drain("busy_start");

        // Reset in the settle window of vector 1 abandons the run.
        issue(4'b1000, 4'h0, 1'b0);
        repeat (3) @(negedge CLK);
        chk("vec1_a", 32'(A), 32'h0);
        chk("vec1_b", 32'(B), 32'hF);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        void'(q.pop_back());
        chk_all_zero("abort_outputs");
        repeat (6) @(negedge CLK);
        chk_all_zero("abort_stays_idle");

        // START held high: a new run starts on the edge right after DONE.
        s0 = 4'b0010;
        s1 = 4'h0;
        glitch = 1'b0;
        e = model(4'b0010, 4'h0);
        e.start = cyc + 1;
        run_start = cyc + 1;
        q.push_back(e);
        START = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!DONE && n < 100);
        chk("held_start_done_seen", 32'(DONE), 32'h1);
        s0 = 4'h0;
        e = model(4'h0, 4'h0);
        e.start = cyc + 1;
        run_start = cyc + 1;
        q.push_back(e);
        @(negedge CLK);
        START = 1'b0;
        chk("held_restart_busy", 32'(BUSY), 32'h1);
        chk("held_restart_done", 32'(DONE), 32'h0);
        wait_drain("held_start");

        for (int r = 0; r < 25; r++) begin
            logic [3:0] f0, f1;
            f0 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            f1 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            issue(f0, f1, 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 8)) @(negedge CLK);
                if (BUSY) begin
                    START = 1'b1;
                    @(negedge CLK);
                    START = 1'b0;
                end
            end
            wait_drain("random");
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mod_74x32_tester.md
MOD_74X32_TESTER -- requirements
Module: mod_74x32_tester

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK is the clock, RST is the reset, and no other clock or asynchronous input SHALL exist.
REQ-002 Parameter SETTLE, default 20, SHALL set the number of clock cycles each stimulus vector is held before its response is checked; legal values are 1 to 255.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 START  input  1  request a test run, sampled on the rising edge of CLK.
REQ-006 Y  input  4  outputs Y1..Y4 of the quad 2-input OR under test (bit n-1 = gate n).
REQ-007 A  output  4  A inputs A1..A4 driven to the device under test.
REQ-008 B  output  4  B inputs B1..B4 driven to the device under test.
REQ-009 BUSY  output  1  high while a run is in progress.
REQ-010 DONE  output  1  high from run completion until the next START or RST.
REQ-011 PASS  output  1  valid while DONE is high: 1 = no mismatch was found.
REQ-012 FAIL_MASK  output  4  sticky per-gate mismatch flags for the current run.
REQ-013 FAIL_VEC  output  2  index of the first vector that mismatched; 0 if none.

Function
REQ-014 Vector order SHALL be: 0 = (A=1,B=1), 1 = (A=0,B=1), 2 = (A=1,B=0), 3 = (A=0,B=0), with the same value on all four gates.
REQ-015 The FSM SHALL have the states IDLE, SETTLE, CHECK and DONE.
REQ-016 IDLE or DONE with START=1: go to SETTLE, drive vector 0, clear FAIL_MASK, FAIL_VEC, PASS and DONE, set BUSY=1, and set the settle counter to 0.
REQ-017 SETTLE: increment the counter each cycle; after SETTLE cycles in this state, go to CHECK.
REQ-018 CHECK, one cycle: for each gate n, a mismatch SHALL be Y[n] != (A[n]|B[n]); OR the mismatches into FAIL_MASK; if this is the first mismatch of the run, load FAIL_VEC with the current vector index.
REQ-019 After CHECK on vector 0..2 with no stop condition, the block SHALL drive the next vector, clear the counter and return to SETTLE.
REQ-020 After CHECK on vector 3, or on a stop condition (REQ-030), the block SHALL go to DONE with BUSY=0, DONE=1 and PASS=(FAIL_MASK==0) including the current check, and A and B SHALL return to 0.
REQ-021 Vector k SHALL be evaluated on the edge (k+1)*(SETTLE+1) after the START edge; DONE SHALL be high exactly 4*(SETTLE+1) cycles after the START edge.
REQ-022 Y SHALL be sampled only in CHECK; changes on Y during SETTLE SHALL be ignored.
REQ-023 START while BUSY=1 SHALL be ignored.
REQ-024 START held high in DONE SHALL restart the run on every qualifying edge, exactly as from IDLE.
REQ-025 A and B SHALL be registered outputs that change only on the edge where a vector is applied.

Reset
REQ-026 RST=1 at a rising edge SHALL force IDLE and set A=0, B=0, BUSY=0, DONE=0, PASS=0, FAIL_MASK=0, FAIL_VEC=0, counter=0.
REQ-027 RST SHALL take priority over START and over any run in progress; a run interrupted by reset is abandoned and leaves no result.
REQ-028 After RST deasserts, the block SHALL stay in IDLE until START is seen.

Configuration
REQ-029 Macro STOP_ON_FAIL_EN SHALL select the early-stop feature at compile time.
REQ-030 With STOP_ON_FAIL_EN defined: a CHECK with any mismatch SHALL go directly to DONE with PASS=0, and the remaining vectors SHALL not be applied.
REQ-031 Without STOP_ON_FAIL_EN: all four vectors SHALL always be applied, and FAIL_MASK SHALL accumulate across them.

Verification
REQ-032 SETTLE=2, good model Y=A|B, pulse START -> DONE=1 after 12 cycles, PASS=1, FAIL_MASK=0000, FAIL_VEC=0.
REQ-033 SETTLE=2, gate 3 Y stuck at 0, macro undefined -> DONE after 12 cycles, PASS=0, FAIL_MASK=0100, FAIL_VEC=0.
REQ-034 SETTLE=2, gate 1 Y stuck at 1 -> FAIL_MASK=0001, FAIL_VEC=3, PASS=0.
REQ-035 STOP_ON_FAIL_EN defined, SETTLE=2, gate 3 Y stuck at 0 -> DONE after 3 cycles, FAIL_MASK=0100, A=B=0000.
REQ-036 Assert RST during the SETTLE of vector 1 -> next cycle all outputs 0 and state IDLE; a START pulse during BUSY -> no change to the run or its 12-cycle timing.
REQ-037 After a failing run, START with a good model -> results cleared on the START edge; final PASS=1, FAIL_MASK=0000.
